mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//  Control stage directly upstream of each neural-network node. Accepts a loaded 64-entry
//  coef/data frame via valid/ready, drives the node's reset_acc/start/cnt_val so it
//  accumulates all products in order, waits for the activation to settle, then captures
//  node_out and holds it for the downstream layer until acknowledged.
// PARAMETERS
//  N_INPUTS   64  products accumulated per frame (2..127)
//  CNT_W      7   width of cnt_val; must satisfy 2**CNT_W > N_INPUTS
//  SETTLE     2   cycles waited after the last product before node_out is sampled (>=1)
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  n_rst         in   1      asynchronous active-low reset
//  frame_valid   in   1      upstream loader: coef/data frame stable and ready to consume
//  frame_ready   out  1      sequencer can accept a frame (handshake completes when both high)
//  reset_acc     out  1      to node: clear accumulator
//  start         out  1      to node: 0 = accumulate (out<=sum), 1 = hold
//  cnt_val       out  CNT_W  to node: index of product being accumulated
//  node_out      in   3      activation output from node
//  result        out  3      captured node_out
//  result_valid  out  1      result held valid until acknowledged
//  result_ack    in   1      downstream consumed result
//  abort         in   1      only present when MAC_SEQ_ABORT_EN defined
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, frame_ready=1, reset_acc=0, start=1,
//    cnt_val=0, result=0, result_valid=0. Reset mid-frame discards all progress.
//  - FSM IDLE -> CLEAR -> ACCUM -> SETTLE -> DONE -> IDLE.
//  - IDLE: frame_ready=1, start=1. On frame_valid&&frame_ready: frame_ready<=0, go CLEAR.
//  - CLEAR (exactly 1 cycle): reset_acc=1, start=1, cnt_val=0.
//  - ACCUM (exactly N_INPUTS cycles): reset_acc=0, start=0, cnt_val=0,1,..,N_INPUTS-1,
//    one increment per cycle; after cnt_val==N_INPUTS-1 go SETTLE. cnt_val never reaches
//    N_INPUTS and never wraps.
//  - SETTLE (SETTLE cycles, down-counter): start=1, cnt_val held at N_INPUTS-1.
//    On last cycle sample node_out into result, result_valid<=1, go DONE.
//  - DONE: result/result_valid held stable until result_ack. On result_ack: result_valid<=0;
//    if frame_valid also high that cycle, go CLEAR directly (back-to-back, frame_ready
//    stays 0); else go IDLE (frame_ready<=1). result retains last value after ack.
//  - result_ack outside DONE ignored. frame_valid outside IDLE/DONE-with-ack ignored; upstream
//    must hold coef/data stable from handshake until the sequencer returns to IDLE.
//  - Frame latency: handshake cycle T -> result_valid high at T+1+1+N_INPUTS+SETTLE
//    (T+68 at defaults). Throughput with immediate ack + back-to-back: 1+N_INPUTS+SETTLE+1.
// CONFIGURATION
//  MAC_SEQ_ABORT_EN defined: abort port exists; abort=1 in CLEAR/ACCUM/SETTLE forces one
//    CLEAR-style cycle (reset_acc=1, start=1, cnt_val=0) then IDLE; no result produced,
//    result/result_valid unchanged. abort in IDLE/DONE ignored. Abort beats frame_valid.
//  Not defined: no abort port; frames always run to completion.
// TESTING
//  1 Reset, frame_valid=1 at cycle 0 -> reset_acc pulse cycle 1, cnt_val 0..63 cycles
//    2..65 with start=0, result_valid=1 at cycle 68, result = node_out sampled cycle 67.
//  2 Hold result_ack=0 for 20 cycles after result_valid -> result, result_valid stable,
//    frame_ready=0, further frame_valid ignored; ack -> result_valid=0, frame_ready=1 next.
//  3 result_ack=1 and frame_valid=1 same cycle in DONE -> next cycle reset_acc=1,
//    frame_ready stays 0, second result after another 67 cycles.
//  4 Assert n_rst=0 when cnt_val=30 -> all outputs at reset values immediately; new frame
//    after release starts at cnt_val=0 with reset_acc pulse.
//  5 N_INPUTS=3, SETTLE=1 -> cnt_val sequence 0,1,2 only, result_valid 6 cycles after handshake.
//  6 MAC_SEQ_ABORT_EN: abort=1 at cnt_val=10 -> one reset_acc pulse, IDLE, frame_ready=1,
//    result_valid stays 0; without macro, same bench runs frame to completion.

Source files
------------

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - frame sequencer driving one MAC node: clear, accumulate, settle, hold result.
// Optional abort input is compiled in when MAC_SEQ_ABORT_EN is defined.
module mac_sequencer #(
    parameter int N_INPUTS = 64,
    parameter int CNT_W    = 7,
    parameter int SETTLE   = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             frame_valid,
    output logic             frame_ready,
    output logic             reset_acc,
    output logic             start,
    output logic [CNT_W-1:0] cnt_val,
    input  logic [2:0]       node_out,
    output logic [2:0]       result,
    output logic             result_valid,
    input  logic             result_ack
`ifdef MAC_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int               SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_SETTLE,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state_q;
    logic [SW-1:0]    settle_q;
    logic             frame_ready_q;
    logic             reset_acc_q;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       result_q;
    logic             result_valid_q;
    logic             abort_d;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_d = abort && (state_q inside {S_CLEAR, S_ACCUM, S_SETTLE});
`else
    assign abort_d = 1'b0;
`endif

    assign frame_ready  = frame_ready_q;
    assign reset_acc    = reset_acc_q;
    assign start        = start_q;
    assign cnt_val      = cnt_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

    // Outputs are loaded together with the state they belong to, so each
    // registered output already reflects the state it is shown in.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            settle_q       <= '0;
            frame_ready_q  <= 1'b1;
            reset_acc_q    <= 1'b0;
            start_q        <= 1'b1;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else if (abort_d) begin
            state_q     <= S_ABORT;
            reset_acc_q <= 1'b1;
            start_q     <= 1'b1;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_valid) begin
                        state_q       <= S_CLEAR;
                        frame_ready_q <= 1'b0;
                        reset_acc_q   <= 1'b1;
                        start_q       <= 1'b1;
                        cnt_q         <= '0;
                    end
                end
                S_CLEAR: begin
                    state_q     <= S_ACCUM;
                    reset_acc_q <= 1'b0;
                    start_q     <= 1'b0;
                    cnt_q       <= '0;
                end
                S_ACCUM: begin
                    if (cnt_q == LAST) begin
                        state_q  <= S_SETTLE;
                        start_q  <= 1'b1;
                        settle_q <= SW'(SETTLE - 1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q        <= S_DONE;
                        result_q       <= node_out;
                        result_valid_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        result_valid_q <= 1'b0;
                        if (frame_valid) begin
                            state_q     <= S_CLEAR;
                            reset_acc_q <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            state_q       <= S_IDLE;
                            frame_ready_q <= 1'b1;
                        end
                    end
                end
                S_ABORT: begin
                    state_q       <= S_IDLE;
                    reset_acc_q   <= 1'b0;
                    frame_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - bench for mac_sequencer (default and small-frame instances; MAC_SEQ_ABORT_EN aware).
module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       fv, ack, ab;
    logic [2:0] node;
    logic       fr, ra, st, rv;
    logic [6:0] cnt;
    logic [2:0] res;

    logic       fv2, ack2;
    logic [2:0] node2;
    logic       fr2, ra2, st2, rv2;
    logic [1:0] cnt2;
    logic [2:0] res2;

    always #5 clk = ~clk;

    mac_sequencer dut (
        .clk(clk), .n_rst(n_rst), .frame_valid(fv), .frame_ready(fr),
        .reset_acc(ra), .start(st), .cnt_val(cnt), .node_out(node),
        .result(res), .result_valid(rv), .result_ack(ack)
`ifdef MAC_SEQ_ABORT_EN
        , .abort(ab)
`endif
    );

    mac_sequencer #(.N_INPUTS(3), .CNT_W(2), .SETTLE(1)) dut2 (
        .clk(clk), .n_rst(n_rst), .frame_valid(fv2), .frame_ready(fr2),
        .reset_acc(ra2), .start(st2), .cnt_val(cnt2), .node_out(node2),
        .result(res2), .result_valid(rv2), .result_ack(ack2)
`ifdef MAC_SEQ_ABORT_EN
        , .abort(1'b0)
`endif
    );

    typedef struct {
        logic [2:0] res;
        int         cyc;
    } sb_t;

    typedef struct {
        int   off;
        logic ra, st, fr, rv;
        int   cnt;
    } vec_t;

    sb_t  sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic rv_prev = 1'b0;

    function automatic logic [2:0] pat(int c);
        return 3'(c * 3 + 1);
    endfunction

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push_frame(int c0);
        sb_t e;
        e.res = pat(c0 + 67);
        e.cyc = c0 + 68;
        sb.push_back(e);
    endtask

    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        node  = pat(cyc);
        node2 = pat(cyc) ^ 3'b101;
        if (rv && !rv_prev) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_result", int'(res), int'(e.res));
                chk("sb_latency_cycle", cyc, e.cyc);
            end
        end
        rv_prev = rv;
    endtask

    task automatic wait_rv(int budget);
        int n = 0;
        while (!rv && n < budget) begin
            step();
            n++;
        end
        if (!rv) chk("wait_rv_timeout", 0, 1);
    endtask

    task automatic ack_once();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        int   c0, c1, n;
        logic [2:0] held;
        logic ok;

        vecs.push_back('{1,  1'b1, 1'b1, 1'b0, 1'b0, 0});
        vecs.push_back('{2,  1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{3,  1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{33, 1'b0, 1'b0, 1'b0, 1'b0, 31});
        vecs.push_back('{65, 1'b0, 1'b0, 1'b0, 1'b0, 63});
        vecs.push_back('{66, 1'b0, 1'b1, 1'b0, 1'b0, 63});
        vecs.push_back('{67, 1'b0, 1'b1, 1'b0, 1'b0, 63});
        vecs.push_back('{68, 1'b0, 1'b1, 1'b0, 1'b1, -1});

        n_rst = 1'b0; fv = 1'b0; ack = 1'b0; ab = 1'b0; node = '0;
        fv2 = 1'b0; ack2 = 1'b0; node2 = '0;
        step();
        step();
        n_rst = 1'b1;

        chk("rst_frame_ready", int'(fr), 1);
        chk("rst_reset_acc", int'(ra), 0);
        chk("rst_start", int'(st), 1);
        chk("rst_cnt_val", int'(cnt), 0);
        chk("rst_result", int'(res), 0);
        chk("rst_result_valid", int'(rv), 0);

        // frame timing against the checkpoint table
        c0 = cyc;
        fv = 1'b1;
        push_frame(c0);
        ok = 1'b1;
        for (int off = 1; off <= 68; off++) begin
            step();
            if (off == 1) fv = 1'b0;
            if (off >= 2 && off <= 65 && (int'(cnt) != off - 2 || st !== 1'b0)) ok = 1'b0;
            for (int i = 0; i < vecs.size(); i++) begin
                if (vecs[i].off == off) begin
                    chk($sformatf("t1_reset_acc@%0d", off), int'(ra), int'(vecs[i].ra));
                    chk($sformatf("t1_start@%0d", off), int'(st), int'(vecs[i].st));
                    chk($sformatf("t1_frame_ready@%0d", off), int'(fr), int'(vecs[i].fr));
                    chk($sformatf("t1_result_valid@%0d", off), int'(rv), int'(vecs[i].rv));
                    if (vecs[i].cnt >= 0)
                        chk($sformatf("t1_cnt_val@%0d", off), int'(cnt), vecs[i].cnt);
                end
            end
        end
        chk("t1_cnt_sequence", int'(ok), 1);

        // result held while ack withheld, extra frame_valid ignored
        held = res;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fv = 1'b1;
            step();
            if (rv !== 1'b1 || res !== held || fr !== 1'b0 || ra !== 1'b0) ok = 1'b0;
        end
        chk("t2_hold_stable", int'(ok), 1);
        fv = 1'b0;
        ack_once();
        chk("t2_rv_cleared", int'(rv), 0);
        chk("t2_frame_ready", int'(fr), 1);
        chk("t2_result_retained", int'(res), int'(held));
        step();
        chk("t2_idle_no_clear", int'(ra), 0);

        // back-to-back frame via ack + frame_valid in DONE
        c0 = cyc;
        fv = 1'b1;
        push_frame(c0);
        step();
        fv = 1'b0;
        wait_rv(100);
        c1 = cyc;
        ack = 1'b1;
        fv = 1'b1;
        push_frame(c1);
        step();
        ack = 1'b0;
        fv = 1'b0;
        chk("t3_reset_acc", int'(ra), 1);
        chk("t3_frame_ready", int'(fr), 0);
        chk("t3_rv_low", int'(rv), 0);
        wait_rv(100);
        chk("t3_second_latency", cyc - c1, 68);
        ack_once();

        // asynchronous reset mid-frame
        fv = 1'b1;
        push_frame(cyc);
        step();
        fv = 1'b0;
        n = 0;
        while (int'(cnt) != 30 && n < 100) begin
            step();
            n++;
        end
        chk("t4_reach_cnt30", int'(cnt), 30);
        #2;
        n_rst = 1'b0;
        #1;
        chk("t4_rst_frame_ready", int'(fr), 1);
        chk("t4_rst_reset_acc", int'(ra), 0);
        chk("t4_rst_start", int'(st), 1);
        chk("t4_rst_cnt_val", int'(cnt), 0);
        chk("t4_rst_result_valid", int'(rv), 0);
        chk("t4_rst_result", int'(res), 0);
        sb.delete();
        rv_prev = 1'b0;
        step();
        n_rst = 1'b1;
        fv = 1'b1;
        push_frame(cyc);
        step();
        fv = 1'b0;
        chk("t4_new_reset_acc", int'(ra), 1);
        chk("t4_new_cnt", int'(cnt), 0);
        step();
        chk("t4_accum_cnt0", int'(cnt), 0);
        chk("t4_accum_start", int'(st), 0);
        wait_rv(100);
        ack_once();

        // short configuration: N_INPUTS=3, SETTLE=1
        c0 = cyc;
        chk("t5_frame_ready", int'(fr2), 1);
        fv2 = 1'b1;
        for (int off = 1; off <= 6; off++) begin
            step();
            if (off == 1) begin
                fv2 = 1'b0;
                chk("t5_reset_acc", int'(ra2), 1);
            end
            if (off >= 2 && off <= 4) begin
                chk($sformatf("t5_cnt@%0d", off), int'(cnt2), off - 2);
                chk($sformatf("t5_start@%0d", off), int'(st2), 0);
            end
            if (off == 5) begin
                chk("t5_settle_start", int'(st2), 1);
                chk("t5_rv_not_early", int'(rv2), 0);
            end
            if (off == 6) begin
                chk("t5_rv", int'(rv2), 1);
                chk("t5_result", int'(res2), int'(pat(c0 + 5) ^ 3'b101));
            end
        end

        // abort at cnt_val==10 (runs to completion without the feature)
        c0 = cyc;
        fv = 1'b1;
`ifndef MAC_SEQ_ABORT_EN
        push_frame(c0);
`endif
        step();
        fv = 1'b0;
        n = 0;
        while (int'(cnt) != 10 && n < 100) begin
            step();
            n++;
        end
        chk("t6_reach_cnt10", int'(cnt), 10);
        ab = 1'b1;
        step();
        ab = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
        chk("t6_abort_reset_acc", int'(ra), 1);
        chk("t6_abort_frame_ready", int'(fr), 0);
        step();
        chk("t6_idle_reset_acc", int'(ra), 0);
        chk("t6_idle_frame_ready", int'(fr), 1);
        ok = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (rv !== 1'b0) ok = 1'b0;
        end
        chk("t6_no_result", int'(ok), 1);
`else
        chk("t6_no_abort_effect", int'(ra), 0);
        wait_rv(100);
        chk("t6_full_latency", cyc - c0, 68);
        ack_once();
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
